nibble_mul_seq: RTL and testbench
=================================

Name: nibble_mul_seq

Overview:
- Sequential OPW x OPW unsigned multiplier controller built around the team's combinational 4x4 `multiplier` stage.
- Splits latched operands into 4-bit nibbles and drives them into the 4x4 stage, one nibble pair per cycle.
- Consumes the 8-bit partial product the 4x4 stage returns, shifts it and accumulates it into a 2*OPW-bit result.
- Sits directly around `multiplier`: its mul_in1/mul_in2 feed the 4x4 stage's in1/in2, and that stage's out returns on mul_out.

Parameters:
- OPW, 8: operand width in bits. Must be a multiple of 4 and at least 4. NIB = OPW/4 nibbles per operand; STEPS = NIB*NIB.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous reset, active-high
- start  input  1  request a new multiply; sampled only when busy=0
- a  input  OPW  multiplicand, sampled with an accepted start
- b  input  OPW  multiplier operand, sampled with an accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse: product valid
- product  output  2*OPW  result, held until the next done
- mul_in1  output  4  nibble of latched a, to 4x4 stage in1
- mul_in2  output  4  nibble of latched b, to 4x4 stage in2
- mul_out  input  8  combinational product from the 4x4 stage

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy=0, done=0, product=0, mul_in1=0, mul_in2=0; internal a_reg, b_reg, acc and counters i, j cleared. Reset overrides every other input, including mid-RUN; an aborted operation produces no done.
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0, mul_in1=mul_in2=0.
  - start=1 -> latch a_reg=a, b_reg=b; acc=0; i=0; j=0; next state RUN.
- RUN: busy=1.
  - mul_in1 = a_reg[4i+3:4i], mul_in2 = b_reg[4j+3:4j], decoded combinationally from the counter registers.
  - Each edge: acc <= acc + (mul_out zero-extended to 2*OPW) << 4*(i+j). The addition is modulo 2^(2*OPW) and never overflows for unsigned operands.
  - Ordering: j increments every cycle. When j=NIB-1, j wraps to 0 and i increments.
  - After the step with i=j=NIB-1: product <= final acc (including that step's term); next state DONE.
- DONE: busy=0, done=1 for exactly one cycle, product valid; mul_in1=mul_in2=0.
  - start=1 in DONE is accepted exactly as in IDLE (latch operands, go RUN). This gives back-to-back throughput of one result per STEPS+1 cycles.
  - Otherwise next state IDLE.
- Latency: start accepted at edge T -> RUN during cycles T+1..T+STEPS -> done=1 in cycle T+STEPS+1. For OPW=8 that is cycle T+5.
- start while busy=1 is ignored. a and b may change freely after acceptance.
- product changes only on entry to DONE (or on reset). It holds its value through IDLE and through the following RUN.
- The block inserts no registers on mul_in1/mul_in2. mul_out must settle within the same cycle.

Optional Feature:
- Macro: NIBBLE_MUL_ZERO_SKIP_EN
- Defined: on an accepted start with a==0 or b==0, skip RUN. Next state is DONE with product=0, so done arrives at T+1. mul_in1/mul_in2 stay 0 and busy stays 0.
- Undefined: zero operands take the full STEPS-cycle RUN path and produce product=0 at T+STEPS+1.

Test Plan:
- rst, then start with a=0x12, b=0x34 at edge T (OPW=8) -> busy=1 for T+1..T+4; done=1 only at T+5; product=0x03A8, held afterwards.
- a=0xAB, b=0xCD -> (mul_in1, mul_in2) over RUN cycles is (B,D), (B,C), (A,D), (A,C); product=0x88EF.
- a=0xFF, b=0xFF; start held high continuously -> product=0xFE01, done pulses every 5 cycles, and starts during RUN are ignored.
- Start a=0x12, b=0x34; assert rst during the 3rd RUN cycle -> next cycle busy=0, done=0, product=0, and no done follows. A subsequent start a=0x02, b=0x03 gives 0x0006.
- a=0x00, b=0x5A -> done at T+5 with product=0 when the macro is undefined; done at T+1 with product=0 and busy never high when NIBBLE_MUL_ZERO_SKIP_EN is defined.
- OPW=16, a=0xFFFF, b=0xFFFF -> 16 RUN cycles; done at T+17; product=0xFFFE0001.

Source files
------------

// File: rtl/nibble_mul_seq_if.sv
// Request/result bundle for the sequential nibble multiplier.
// The master issues start/a/b; the slave returns busy/done/product.
interface nibble_mul_seq_if #(
    parameter int OPW = 8
);
    logic              start;
    logic [OPW-1:0]    a;
    logic [OPW-1:0]    b;
    logic              busy;
    logic              done;
    logic [2*OPW-1:0]  product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/nibble_mul_seq.sv
// Sequential OPW x OPW multiplier driving an external 4x4 multiplier stage.
// Optional NIBBLE_MUL_ZERO_SKIP_EN: zero operands bypass RUN and finish at once.
module nibble_mul_seq #(
    parameter int OPW = 8
) (
    input  logic             clk,
    input  logic             rst,
    nibble_mul_seq_if.slave  bus,
    output logic [3:0]       mul_in1,
    output logic [3:0]       mul_in2,
    input  logic [7:0]       mul_out
);
    localparam int NIB = OPW / 4;
    localparam int PW  = 2 * OPW;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [OPW-1:0]  a_reg_q, a_reg_d;
    logic [OPW-1:0]  b_reg_q, b_reg_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   product_q, product_d;
    logic [CW-1:0]   i_q, i_d;
    logic [CW-1:0]   j_q, j_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [OPW-1:0]  a_sh;
    logic [OPW-1:0]  b_sh;
    logic [CW:0]     ij;
    logic [PW-1:0]   term;
    logic [PW-1:0]   acc_sum;

    // Nibble select and partial-product alignment come straight off the counters.
    always_comb begin
        a_sh = a_reg_q >> {i_q, 2'b00};
        b_sh = b_reg_q >> {j_q, 2'b00};
        ij = {1'b0, i_q} + {1'b0, j_q};
        term = '0;
        term[7:0] = mul_out;
        term = term << {ij, 2'b00};
        acc_sum = acc_q + term;
    end

    always_comb begin
        mul_in1 = 4'h0;
        mul_in2 = 4'h0;
        if (state_q == RUN) begin
            mul_in1 = a_sh[3:0];
            mul_in2 = b_sh[3:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        a_reg_d   = a_reg_q;
        b_reg_d   = b_reg_q;
        acc_d     = acc_q;
        product_d = product_q;
        i_d       = i_q;
        j_d       = j_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    a_reg_d = bus.a;
                    b_reg_d = bus.b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = RUN;
`ifdef NIBBLE_MUL_ZERO_SKIP_EN
                    if (bus.a == '0 || bus.b == '0) begin
                        product_d = '0;
                        state_d   = DONE;
                    end
`endif
                end
            end
            RUN: begin
                acc_d = acc_sum;
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        i_d       = '0;
                        product_d = acc_sum;
                        state_d   = DONE;
                    end else begin
                        i_d = i_q + CW'(1);
                    end
                end else begin
                    j_d = j_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_reg_q   <= '0;
            b_reg_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
            i_q       <= '0;
            j_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_reg_q   <= a_reg_d;
            b_reg_q   <= b_reg_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            i_q       <= i_d;
            j_q       <= j_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_nibble_mul_seq.sv
// Directed bench for nibble_mul_seq with OPW=8 and OPW=16 instances.
// The 4x4 stage is modelled as a plain combinational multiply.
module tb_nibble_mul_seq;
    logic clk;
    logic rst;

    logic [3:0] mi1_8, mi2_8, mi1_16, mi2_16;
    logic [7:0] mo_8, mo_16;

    int n_assert;
    int n_fail;

    nibble_mul_seq_if #(.OPW(8))  bus8 ();
    nibble_mul_seq_if #(.OPW(16)) bus16 ();

    nibble_mul_seq #(.OPW(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus8),
        .mul_in1 (mi1_8),
        .mul_in2 (mi2_8),
        .mul_out (mo_8)
    );

    nibble_mul_seq #(.OPW(16)) dut16 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus16),
        .mul_in1 (mi1_16),
        .mul_in2 (mi2_16),
        .mul_out (mo_16)
    );

    assign mo_8  = {4'h0, mi1_8} * {4'h0, mi2_8};
    assign mo_16 = {4'h0, mi1_16} * {4'h0, mi2_16};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // pairs packs {mul_in1,mul_in2} per RUN step, first step in the top byte.
    task automatic mul8(input logic [7:0] aa, input logic [7:0] bb,
                        input logic [15:0] exp, input logic [31:0] pairs,
                        input bit do_pairs);
        logic [31:0] p;
        p = pairs;
        bus8.start = 1'b1;
        bus8.a = aa;
        bus8.b = bb;
        tick;
        bus8.start = 1'b0;
        bus8.a = ~aa;
        bus8.b = ~bb;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("run%0d_busy", k), bus8.busy, 1);
            chk($sformatf("run%0d_done", k), bus8.done, 0);
            if (do_pairs)
                chk($sformatf("run%0d_pair", k), {mi1_8, mi2_8}, p[31:24]);
            p = p << 8;
            tick;
        end
        chk("done_hi", bus8.done, 1);
        chk("done_busy", bus8.busy, 0);
        chk("done_product", bus8.product, exp);
        chk("done_mulin", {mi1_8, mi2_8}, 0);
        tick;
        chk("done_pulse", bus8.done, 0);
        chk("product_hold", bus8.product, exp);
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        rst = 1'b1;
        bus8.start = 1'b0;
        bus8.a = '0;
        bus8.b = '0;
        bus16.start = 1'b0;
        bus16.a = '0;
        bus16.b = '0;
        tick;
        tick;
        chk("rst_busy", bus8.busy, 0);
        chk("rst_done", bus8.done, 0);
        chk("rst_product", bus8.product, 0);
        chk("rst_mulin", {mi1_8, mi2_8}, 0);
        chk("rst16_product", bus16.product, 0);
        rst = 1'b0;
        tick;

        mul8(8'h12, 8'h34, 16'h03A8, 32'h24_23_14_13, 1'b1);
        tick;
        chk("idle_hold", bus8.product, 16'h03A8);

        mul8(8'hAB, 8'hCD, 16'h88EF, 32'hBD_BC_AD_AC, 1'b1);

        // Start held high: one result every 5 cycles, RUN-time starts ignored.
        bus8.start = 1'b1;
        bus8.a = 8'hFF;
        bus8.b = 8'hFF;
        tick;
        for (int k = 1; k <= 15; k++) begin
            chk($sformatf("b2b%0d_done", k), bus8.done, (k % 5 == 0));
            chk($sformatf("b2b%0d_busy", k), bus8.busy, (k % 5 != 0));
            if (k % 5 == 0)
                chk($sformatf("b2b%0d_product", k), bus8.product, 16'hFE01);
            if (k == 15)
                bus8.start = 1'b0;
            tick;
        end
        chk("b2b_idle_busy", bus8.busy, 0);
        chk("b2b_idle_done", bus8.done, 0);

        // Reset during the third RUN cycle aborts with no done.
        bus8.start = 1'b1;
        bus8.a = 8'h12;
        bus8.b = 8'h34;
        tick;
        bus8.start = 1'b0;
        tick;
        tick;
        chk("abort_pre_busy", bus8.busy, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_busy", bus8.busy, 0);
        chk("abort_done", bus8.done, 0);
        chk("abort_product", bus8.product, 0);
        chk("abort_mulin", {mi1_8, mi2_8}, 0);
        for (int k = 0; k < 6; k++) begin
            tick;
            chk($sformatf("abort_nodone%0d", k), bus8.done, 0);
        end
        mul8(8'h02, 8'h03, 16'h0006, 32'h23_20_03_00, 1'b1);

`ifdef NIBBLE_MUL_ZERO_SKIP_EN
        bus8.start = 1'b1;
        bus8.a = 8'h00;
        bus8.b = 8'h5A;
        tick;
        bus8.start = 1'b0;
        chk("zskip_done", bus8.done, 1);
        chk("zskip_busy", bus8.busy, 0);
        chk("zskip_product", bus8.product, 0);
        chk("zskip_mulin", {mi1_8, mi2_8}, 0);
        tick;
        chk("zskip_pulse", bus8.done, 0);
        chk("zskip_busy2", bus8.busy, 0);
`else
        mul8(8'h00, 8'h5A, 16'h0000, 32'h0A_05_0A_05, 1'b1);
`endif

        // OPW=16: 16 RUN cycles, done at T+17.
        bus16.start = 1'b1;
        bus16.a = 16'hFFFF;
        bus16.b = 16'hFFFF;
        tick;
        bus16.start = 1'b0;
        bus16.a = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("w16_run%0d_busy", k), bus16.busy, 1);
            chk($sformatf("w16_run%0d_pair", k), {mi1_16, mi2_16}, 8'hFF);
            if (bus16.done)
                chk($sformatf("w16_run%0d_done", k), bus16.done, 0);
            tick;
        end
        chk("w16_done", bus16.done, 1);
        chk("w16_busy", bus16.busy, 0);
        chk("w16_product", bus16.product, 32'hFFFE0001);
        tick;
        chk("w16_pulse", bus16.done, 0);
        chk("w16_hold", bus16.product, 32'hFFFE0001);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
